// File: rtl/shift_pkg.sv
// Shared definitions for the fftshift / ifftshift frame buffers: default
// widths, the two-state frame FSM encoding and the half-length helper.
package shift_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;

  // FILL: accepting samples into the RAM; READ: emitting the rotated frame.
  typedef enum logic {
    FILL = 1'b0,
    READ = 1'b1
  } state_e;

  // Rotation offset for the inverse shift; the forward shift passes n+1.
  function automatic int unsigned half_len(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/ram_ifftshift_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Ports: clk, rst (clears the read register only), we/waddr/wdata write
// port, re/raddr read request, q read data one cycle after re.
module sdp_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_ifftshift.sv
// Streaming ifftshift: buffers a frame of N samples in order, then replays
// it as out[k] = in[(k + N/2) mod N].
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_last/in_ready
// input stream; out_valid/out_data/out_last output stream (no backpressure);
// busy high while a frame is emitted; err_ovf pulses when a frame is forced
// closed at DEPTH samples without in_last.
module ram_ifftshift
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_ovf
);

  state_e            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W:0]   n_len;
  logic [ADDR_W:0]   n_last;
  logic              first;
  logic              rd_en;
  logic              wr_en;

  assign n_last = n_len - (ADDR_W+1)'(1);
  assign wr_en  = (state == FILL) && in_valid;

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_ptr),
    .q     (out_data)
  );

  // Frame FSM: fill, then one setup cycle followed by N read addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      n_len     <= '0;
      first     <= 1'b0;
      rd_en     <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_ovf   <= 1'b0;
      // RAM q lands on the same edge, so valid/last just follow the address.
      out_valid <= rd_en;
      out_last  <= rd_en && ({1'b0, rd_cnt} == n_last);

      case (state)
        FILL: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (in_last || (wr_ptr == {ADDR_W{1'b1}})) begin
              n_len    <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
              state    <= READ;
              first    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              err_ovf  <= !in_last;
            end
          end
        end

        READ: begin
          if (first) begin
            first  <= 1'b0;
            rd_ptr <= ADDR_W'(half_len(32'(n_len)));
            rd_cnt <= '0;
            rd_en  <= 1'b1;
          end else begin
            // Wrap by compare so no modulo hardware is needed.
            rd_ptr <= ({1'b0, rd_ptr} == n_last) ? '0 : rd_ptr + ADDR_W'(1);
            rd_cnt <= rd_cnt + ADDR_W'(1);
            if ({1'b0, rd_cnt} == n_last) begin
              state    <= FILL;
              wr_ptr   <= '0;
              rd_en    <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ifftshift.sv
// Self-checking bench for ram_ifftshift: directed frames plus random frames
// compared against a queue-based rotation model.
module tb_ram_ifftshift;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  typedef logic [DATA_W-1:0] q8_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err_ovf;

  ram_ifftshift #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture
  logic [DATA_W-1:0] cap_d[$];
  bit                cap_l[$];
  int unsigned       cap_c[$];
  int                ovf_cnt = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_d.push_back(out_data);
      cap_l.push_back(out_last);
      cap_c.push_back(cyc);
    end
    if (err_ovf) ovf_cnt++;
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: out[k] = in[(k + floor(N/2)) mod N]
  function automatic q8_t ishift(input q8_t d);
    q8_t e;
    int n;
    n = d.size();
    for (int k = 0; k < n; k++) e.push_back(d[(k + n / 2) % n]);
    return e;
  endfunction

  function automatic q8_t ramp(input int first_val, input int n);
    q8_t d;
    for (int i = 0; i < n; i++) d.push_back(DATA_W'(first_val + i));
    return d;
  endfunction

  // Drive one frame; keeps in_valid high while stalled. acc = accept cycle of last sample.
  task automatic send_frame(input q8_t d, input bit use_last, input bit hold,
                            output int unsigned acc);
    acc = 0;
    for (int i = 0; i < d.size(); i++) begin
      int w;
      in_valid = 1'b1;
      in_data  = d[i];
      in_last  = use_last && (i == d.size() - 1);
      w = 0;
      while (!in_ready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        break;
      end
      @(negedge clk);
      acc = cyc;
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Wait for and compare one emitted frame, including latency of first/last output.
  task automatic check_frame(input q8_t inq, input string tag, input int unsigned acc);
    q8_t e;
    int n;
    int w;
    e = ishift(inq);
    n = e.size();
    w = 0;
    while (cap_d.size() < n && w < n + 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, "_count"}, {31'd0, cap_d.size() >= n}, 32'd1);
    if (cap_d.size() < n) return;
    for (int k = 0; k < n; k++) begin
      logic [DATA_W-1:0] d;
      bit l;
      int unsigned c;
      d = cap_d.pop_front();
      l = cap_l.pop_front();
      c = cap_c.pop_front();
      check($sformatf("%s_data%0d", tag, k), 32'(d), 32'(e[k]));
      check($sformatf("%s_last%0d", tag, k), {31'd0, l}, {31'd0, k == n - 1});
      if (k == 0) check({tag, "_lat_first"}, c - acc, 32'd2);
      if (k == n - 1) check({tag, "_lat_last"}, c - acc, 32'(n + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    q8_t f1, f2;
    int unsigned acc1, acc2;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_err_ovf",   {31'd0, err_ovf},   32'd0);
    check("rst_out_data",  32'(out_data),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // in_last without in_valid must not close a frame
    in_last = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_last_ready", {31'd0, in_ready}, 32'd1);
    check("idle_last_busy",  {31'd0, busy},     32'd0);
    in_last = 1'b0;

    // Odd N
    f1 = ramp(1, 9);
    send_frame(f1, 1'b1, 1'b0, acc1);
    check("odd_busy",  {31'd0, busy},     32'd1);
    check("odd_ready", {31'd0, in_ready}, 32'd0);
    check_frame(f1, "odd9", acc1);

    // Even N
    f1 = ramp(1, 8);
    send_frame(f1, 1'b1, 1'b0, acc1);
    check_frame(f1, "even8", acc1);

    // Round trip from fftshift output
    f1 = '{8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    send_frame(f1, 1'b1, 1'b0, acc1);
    check_frame(f1, "round", acc1);

    // N=1
    f1 = '{8'h2A};
    send_frame(f1, 1'b1, 1'b0, acc1);
    check_frame(f1, "n1", acc1);

    // N=2
    f1 = '{8'hA5, 8'h5A};
    send_frame(f1, 1'b1, 1'b0, acc1);
    check_frame(f1, "n2", acc1);

    // Back-to-back with in_valid held across READ
    f1 = ramp(1, 4);
    f2 = ramp(10, 5);
    send_frame(f1, 1'b1, 1'b1, acc1);
    send_frame(f2, 1'b1, 1'b0, acc2);
    check_frame(f1, "b2b_a", acc1);
    check_frame(f2, "b2b_b", acc2);

    // Overflow: 256 samples without in_last
    ovf_cnt = 0;
    f1 = ramp(0, 256);
    send_frame(f1, 1'b0, 1'b0, acc1);
    check_frame(f1, "ovf", acc1);
    check("ovf_pulses", 32'(ovf_cnt), 32'd1);

    // Random frames
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 40);
      f1 = {};
      for (int i = 0; i < n; i++) f1.push_back(DATA_W'($urandom));
      send_frame(f1, 1'b1, 1'b0, acc1);
      check_frame(f1, $sformatf("rnd%0d", r), acc1);
    end

    // Reset during READ on the third output
    f1 = ramp(1, 9);
    send_frame(f1, 1'b1, 1'b0, acc1);
    begin
      int w;
      w = 0;
      while (cap_d.size() < 3 && w < 50) begin
        @(negedge clk);
        #1;
        w++;
      end
    end
    check("mid_count3", 32'(cap_d.size()), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_busy",      {31'd0, busy},      32'd0);
    check("mid_out_last",  {31'd0, out_last},  32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_no_more", 32'(cap_d.size()), 32'd3);
    begin
      int nl;
      nl = 0;
      foreach (cap_l[i]) if (cap_l[i]) nl++;
      check("mid_no_last", 32'(nl), 32'd0);
    end
    cap_d = {};
    cap_l = {};
    cap_c = {};

    f1 = ramp(1, 3);
    send_frame(f1, 1'b1, 1'b0, acc1);
    check_frame(f1, "post_rst", acc1);

    repeat (5) @(negedge clk);
    #1;
    check("no_extra_out", 32'(cap_d.size()), 32'd0);
    check("ovf_total", 32'(ovf_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
